// File: rtl/lsu_mem_if.sv
// Load/store unit: RV32I byte/half/word accesses mapped onto a word-wide memory with byte write mask.
// Define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses into two word accesses instead of erroring.
module lsu_mem_if #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_we,
  output logic [3:0]        mem_wmask,
  output logic [ADDR_W-1:0] mem_a,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
`ifdef LSU_MISALIGN_SPLIT_EN
    ACC1 = 2'd2,
`endif
    RESP = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                store_q, store_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [1:0]          off_q, off_d;
  logic                mem_we_q, mem_we_d;
  logic [3:0]          mem_wmask_q, mem_wmask_d;
  logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
  logic [31:0]         mem_wd_q, mem_wd_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic [31:0]         ld_word;
  logic                req_illegal;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         lo_q, lo_d;
  logic [31:0]         ld_pair;
  logic                crossing;
`endif

  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] f3);
    logic [31:0] r;
    case (f3[1:0])
      2'b00:   r = {{24{w[7] & ~f3[2]}}, w[7:0]};
      2'b01:   r = {{16{w[15] & ~f3[2]}}, w[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  // Unsigned stores have no meaning, so funct3[2] on a store is rejected like an unused encoding.
  always_comb begin
    req_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                  (req_store && req_funct3[2]);
`ifndef LSU_MISALIGN_SPLIT_EN
    if ((req_funct3[1:0] == 2'b01 && req_addr[0]) ||
        (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00))
      req_illegal = 1'b1;
`endif
  end

`ifdef LSU_MISALIGN_SPLIT_EN
  assign crossing = (funct3_q[1:0] == 2'b01 && off_q == 2'd3) ||
                    (funct3_q[1:0] == 2'b10 && off_q != 2'd0);
`endif

  always_comb begin
    state_d     = state_q;
    store_d     = store_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    mem_we_d    = 1'b0;
    mem_wmask_d = mem_wmask_q;
    mem_a_d     = mem_a_q;
    mem_wd_d    = mem_wd_q;
    rsp_rdata_d = 32'd0;
    rsp_err_d   = 1'b0;
    ld_word     = mem_rd >> {off_q, 3'b000};
`ifdef LSU_MISALIGN_SPLIT_EN
    wdata_d     = wdata_q;
    lo_d        = lo_q;
    ld_pair     = 32'({mem_rd, lo_q} >> {off_q, 3'b000});
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          store_d  = req_store;
          funct3_d = req_funct3;
          off_d    = req_addr[1:0];
`ifdef LSU_MISALIGN_SPLIT_EN
          wdata_d  = req_wdata;
`endif
          if (req_illegal) begin
            state_d   = RESP;
            rsp_err_d = 1'b1;
          end else begin
            state_d     = ACC0;
            mem_a_d     = {req_addr[ADDR_W-1:2], 2'b00};
            mem_we_d    = req_store;
            mem_wmask_d = req_store ? (size_mask(req_funct3[1:0]) << req_addr[1:0]) : 4'b0000;
            mem_wd_d    = req_wdata << {req_addr[1:0], 3'b000};
          end
        end
      end
      ACC0: begin
`ifdef LSU_MISALIGN_SPLIT_EN
        // Second half: the lanes shifted out of the first word land at the bottom of the next.
        if (crossing) begin
          state_d     = ACC1;
          mem_a_d     = mem_a_q + ADDR_W'(4);
          mem_we_d    = store_q;
          mem_wmask_d = store_q ? (size_mask(funct3_q[1:0]) >> (3'd4 - {1'b0, off_q})) : 4'b0000;
          mem_wd_d    = wdata_q >> (6'd32 - {1'b0, off_q, 3'b000});
          lo_d        = mem_rd;
        end else
`endif
        begin
          state_d     = RESP;
          rsp_rdata_d = store_q ? 32'd0 : extend(ld_word, funct3_q);
        end
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      ACC1: begin
        state_d     = RESP;
        rsp_rdata_d = store_q ? 32'd0 : extend(ld_pair, funct3_q);
      end
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      store_q     <= 1'b0;
      funct3_q    <= 3'd0;
      off_q       <= 2'd0;
      mem_we_q    <= 1'b0;
      mem_wmask_q <= 4'd0;
      mem_a_q     <= '0;
      mem_wd_q    <= 32'd0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
      wdata_q     <= 32'd0;
      lo_q        <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      store_q     <= store_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      mem_we_q    <= mem_we_d;
      mem_wmask_q <= mem_wmask_d;
      mem_a_q     <= mem_a_d;
      mem_wd_q    <= mem_wd_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef LSU_MISALIGN_SPLIT_EN
      wdata_q     <= wdata_d;
      lo_q        <= lo_d;
`endif
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_we    = mem_we_q;
  assign mem_wmask = mem_wmask_q;
  assign mem_a     = mem_a_q;
  assign mem_wd    = mem_wd_q;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Bench for lsu_mem_if: directed cases plus randomized ops against a byte-addressed memory model.
module tb_lsu_mem_if;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] tb_mem [1024];
  logic [7:0]  ref_bytes [4096];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_idx = 10'd0;
  logic [31:0] pl_dat = 32'd0;

  int          n_tests = 0;
  int          n_fail = 0;
  int          nwr;
  logic [31:0] wr_a [2];
  logic [31:0] wr_d [2];
  logic [3:0]  wr_m [2];
  logic [31:0] acc_a [2];

  lsu_mem_if #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_we(mem_we), .mem_wmask(mem_wmask), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = tb_mem[mem_a[11:2]];

  always @(posedge clk) begin
    if (pl_en) tb_mem[pl_idx] <= pl_dat;
    else if (mem_we)
      for (int i = 0; i < 4; i++)
        if (mem_wmask[i]) tb_mem[mem_a[11:2]][8*i +: 8] <= mem_wd[8*i +: 8];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int op_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic model_err(input logic st, input logic [2:0] f3, input logic [31:0] a);
    int n = op_size(f3);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if (st && f3[2]) return 1'b1;
`ifndef LSU_MISALIGN_SPLIT_EN
    if ((int'(a[1:0]) % n) != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic model_cross(input logic [2:0] f3, input logic [31:0] a);
    return (int'(a[1:0]) + op_size(f3)) > 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    int n = op_size(f3);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_bytes[(a + i) & 32'hFFF]) << (8 * i));
    if (!f3[2] && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
    if (!f3[2] && n == 2 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < op_size(f3); i++) ref_bytes[(a + i) & 32'hFFF] = d[8*i +: 8];
  endtask

  // ---------------- drivers ----------------
  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    pl_en = 1'b1; pl_idx = a[11:2]; pl_dat = w;
    @(negedge clk);
    pl_en = 1'b0;
    for (int i = 0; i < 4; i++) ref_bytes[{a[11:2], 2'b00} + i] = w[8*i +: 8];
  endtask

  // Called at a negedge; returns at the negedge where rsp_valid is seen (lat = cycles after accept).
  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd,
                        output logic er, output logic rdy_at_rsp);
    int guard = 0;
    nwr = 0; lat = 0; rd = 32'd0; er = 1'b0; rdy_at_rsp = 1'b1;
    acc_a[0] = 32'hX; acc_a[1] = 32'hX;
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
    for (int k = 1; k <= 8; k++) begin
      if (k <= 2) acc_a[k-1] = mem_a;
      if (mem_we) begin
        if (nwr < 2) begin wr_a[nwr] = mem_a; wr_m[nwr] = mem_wmask; wr_d[nwr] = mem_wd; end
        nwr++;
      end
      if (rsp_valid) begin
        lat = k; rd = rsp_rdata; er = rsp_err; rdy_at_rsp = req_ready;
        break;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int w = 0; w < 1024; w++) preload(32'(w * 4), $urandom);
    n_tests++;
    if ({mem_we, mem_wmask, mem_a, mem_wd} !== 69'd0) begin
      n_fail++; $display("FAIL reset_mem_outputs: got we=%b m=%b a=%h wd=%h want all zero", mem_we, mem_wmask, mem_a, mem_wd);
    end
    n_tests++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== 34'd0) begin
      n_fail++; $display("FAIL reset_rsp_outputs: got v=%b e=%b d=%h want all zero", rsp_valid, rsp_err, rsp_rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_byte_loads();
    int lat; logic [31:0] rd; logic er, rdy;
    preload(32'h100, 32'h80FF_FFFF);
    run_op(1'b0, 3'b000, 32'h103, 32'd0, lat, rd, er, rdy);
    n_tests++;
    if (rd !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_data: got %h want ffffff80", rd); end
    n_tests++;
    if (lat !== 2) begin n_fail++; $display("FAIL lb_latency: got %0d want 2", lat); end
    run_op(1'b0, 3'b100, 32'h103, 32'd0, lat, rd, er, rdy);
    n_tests++;
    if (rd !== 32'h0000_0080 || er !== 1'b0) begin n_fail++; $display("FAIL lbu_data: got %h err %b want 00000080 err 0", rd, er); end
  endtask

  task automatic test_half_store();
    int lat; logic [31:0] rd; logic er, rdy;
    run_op(1'b1, 3'b001, 32'h202, 32'h0000_BEEF, lat, rd, er, rdy);
    model_store(3'b001, 32'h202, 32'h0000_BEEF);
    n_tests++;
    if (nwr !== 1) begin n_fail++; $display("FAIL sh_write_count: got %0d want 1", nwr); end
    n_tests++;
    if (wr_a[0] !== 32'h200 || wr_m[0] !== 4'b1100 || wr_d[0] !== 32'hBEEF_0000) begin
      n_fail++; $display("FAIL sh_lanes: got a=%h m=%b d=%h want a=00000200 m=1100 d=beef0000", wr_a[0], wr_m[0], wr_d[0]);
    end
    n_tests++;
    if (rd !== 32'd0 || er !== 1'b0 || lat !== 2) begin n_fail++; $display("FAIL sh_response: got d=%h e=%b lat=%0d want 0 0 2", rd, er, lat); end
  endtask

  task automatic test_misaligned_word();
    int lat; logic [31:0] rd; logic er, rdy;
    preload(32'h300, 32'h4433_2211);
    preload(32'h304, 32'h8877_6655);
    preload(32'h400, 32'h0102_0304);
    preload(32'h404, 32'h0506_0708);
    run_op(1'b0, 3'b010, 32'h301, 32'd0, lat, rd, er, rdy);
`ifdef LSU_MISALIGN_SPLIT_EN
    n_tests++;
    if (rd !== 32'h5544_3322 || er !== 1'b0) begin n_fail++; $display("FAIL lw_split_data: got %h err %b want 55443322 err 0", rd, er); end
    n_tests++;
    if (lat !== 3) begin n_fail++; $display("FAIL lw_split_latency: got %0d want 3", lat); end
    n_tests++;
    if (acc_a[0] !== 32'h300 || acc_a[1] !== 32'h304) begin n_fail++; $display("FAIL lw_split_addr: got %h,%h want 00000300,00000304", acc_a[0], acc_a[1]); end
    run_op(1'b1, 3'b010, 32'h403, 32'hAABB_CCDD, lat, rd, er, rdy);
    model_store(3'b010, 32'h403, 32'hAABB_CCDD);
    n_tests++;
    if (nwr !== 2) begin n_fail++; $display("FAIL sw_split_count: got %0d want 2", nwr); end
    n_tests++;
    if (wr_a[0] !== 32'h400 || wr_m[0] !== 4'b1000 || wr_d[0] !== 32'hDD00_0000) begin
      n_fail++; $display("FAIL sw_split_first: got a=%h m=%b d=%h want 00000400 1000 dd000000", wr_a[0], wr_m[0], wr_d[0]);
    end
    n_tests++;
    if (wr_a[1] !== 32'h404 || wr_m[1] !== 4'b0111 || wr_d[1] !== 32'h00AA_BBCC) begin
      n_fail++; $display("FAIL sw_split_second: got a=%h m=%b d=%h want 00000404 0111 00aabbcc", wr_a[1], wr_m[1], wr_d[1]);
    end
`else
    n_tests++;
    if (er !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL lw_misalign_err: got err %b d %h want err 1 d 0", er, rd); end
    n_tests++;
    if (lat !== 1) begin n_fail++; $display("FAIL lw_misalign_latency: got %0d want 1", lat); end
    run_op(1'b1, 3'b010, 32'h403, 32'hAABB_CCDD, lat, rd, er, rdy);
    n_tests++;
    if (nwr !== 0 || er !== 1'b1) begin n_fail++; $display("FAIL sw_misalign: got writes %0d err %b want 0 writes err 1", nwr, er); end
`endif
  endtask

  task automatic test_illegal();
    int lat; logic [31:0] rd; logic er, rdy;
    run_op(1'b0, 3'b011, 32'h100, 32'd0, lat, rd, er, rdy);
    n_tests++;
    if (er !== 1'b1 || lat !== 1 || nwr !== 0 || rd !== 32'd0) begin
      n_fail++; $display("FAIL illegal_load: got err %b lat %0d writes %0d d %h want 1 1 0 0", er, lat, nwr, rd);
    end
    run_op(1'b1, 3'b100, 32'h100, 32'h1234_5678, lat, rd, er, rdy);
    n_tests++;
    if (er !== 1'b1 || lat !== 1 || nwr !== 0) begin
      n_fail++; $display("FAIL illegal_store: got err %b lat %0d writes %0d want 1 1 0", er, lat, nwr);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd; logic er, rdy;
    run_op(1'b1, 3'b010, 32'h600, 32'hCAFE_F00D, lat, rd, er, rdy);
    model_store(3'b010, 32'h600, 32'hCAFE_F00D);
    n_tests++;
    if (rdy !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_in_rsp: got %b want 0", rdy); end
    @(negedge clk);
    n_tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_rsp_pulse: got valid %b ready %b want 0 1", rsp_valid, req_ready);
    end
    run_op(1'b0, 3'b010, 32'h600, 32'd0, lat, rd, er, rdy);
    n_tests++;
    if (rd !== 32'hCAFE_F00D || lat !== 2) begin n_fail++; $display("FAIL b2b_lw: got %h lat %0d want cafef00d lat 2", rd, lat); end
    run_op(1'b0, 3'b100, 32'h601, 32'd0, lat, rd, er, rdy);
    n_tests++;
    if (rd !== 32'h0000_00F0 || lat !== 2) begin n_fail++; $display("FAIL b2b_lbu: got %h lat %0d want 000000f0 lat 2", rd, lat); end
  endtask

  task automatic test_random();
    int lat, exp_lat, exp_nwr, bad_words;
    logic [31:0] rd, a, wd, exp_rd;
    logic er, rdy, st, exp_er, crs;
    logic [2:0] f3;
    for (int i = 0; i < 300; i++) begin
      st = 1'($urandom); f3 = 3'($urandom); a = $urandom_range(0, 4095); wd = $urandom;
      exp_er  = model_err(st, f3, a);
      crs     = model_cross(f3, a);
      exp_lat = exp_er ? 1 : (crs ? 3 : 2);
      exp_nwr = (st && !exp_er) ? (crs ? 2 : 1) : 0;
      exp_rd  = (st || exp_er) ? 32'd0 : model_load(f3, a);
      run_op(st, f3, a, wd, lat, rd, er, rdy);
      if (st && !exp_er) model_store(f3, a, wd);
      n_tests++;
      if (rd !== exp_rd || er !== exp_er) begin
        n_fail++; $display("FAIL rand[%0d] st=%b f3=%b a=%h: got d=%h e=%b want d=%h e=%b", i, st, f3, a, rd, er, exp_rd, exp_er);
      end
      n_tests++;
      if (lat !== exp_lat || nwr !== exp_nwr) begin
        n_fail++; $display("FAIL rand[%0d] timing st=%b f3=%b a=%h: got lat=%0d wr=%0d want lat=%0d wr=%0d", i, st, f3, a, lat, nwr, exp_lat, exp_nwr);
      end
    end
    @(negedge clk);
    bad_words = 0;
    for (int w = 0; w < 1024; w++)
      if (tb_mem[w] !== {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]}) bad_words++;
    n_tests++;
    if (bad_words != 0) begin n_fail++; $display("FAIL memory_image: got %0d differing words want 0", bad_words); end
  endtask

  task automatic test_reset_mid_op();
    int bad_rsp = 0;
    preload(32'h400, 32'h1111_1111);
    preload(32'h404, 32'h2222_2222);
    preload(32'h500, 32'h3333_3333);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010; req_wdata = 32'hAABB_CCDD;
`ifdef LSU_MISALIGN_SPLIT_EN
    req_addr = 32'h403;
`else
    req_addr = 32'h500;
`endif
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
    @(negedge clk);
    n_tests++;
    if (mem_we !== 1'b1 || mem_a !== 32'h404) begin n_fail++; $display("FAIL rst_mid_in_acc1: got we %b a %h want 1 00000404", mem_we, mem_a); end
`endif
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({mem_we, mem_wmask, mem_a, mem_wd, rsp_valid, rsp_err, rsp_rdata} !== 103'd0) begin
      n_fail++; $display("FAIL rst_mid_outputs: got we=%b m=%b a=%h wd=%h v=%b e=%b d=%h want all zero", mem_we, mem_wmask, mem_a, mem_wd, rsp_valid, rsp_err, rsp_rdata);
    end
    repeat (3) begin @(negedge clk); if (rsp_valid !== 1'b0) bad_rsp++; end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 1", req_ready); end
    repeat (3) begin if (rsp_valid !== 1'b0) bad_rsp++; @(negedge clk); end
    n_tests++;
    if (bad_rsp != 0) begin n_fail++; $display("FAIL rst_mid_no_rsp: got %0d valid cycles want 0", bad_rsp); end
`ifdef LSU_MISALIGN_SPLIT_EN
    ref_bytes[32'h403] = 8'hDD;
    n_tests++;
    if (tb_mem[32'h404 >> 2] !== 32'h2222_2222 || tb_mem[32'h400 >> 2] !== 32'hDD11_1111) begin
      n_fail++; $display("FAIL rst_mid_memory: got 400=%h 404=%h want dd111111 22222222", tb_mem[32'h400 >> 2], tb_mem[32'h404 >> 2]);
    end
`else
    n_tests++;
    if (tb_mem[32'h500 >> 2] !== 32'h3333_3333) begin
      n_fail++; $display("FAIL rst_mid_memory: got 500=%h want 33333333", tb_mem[32'h500 >> 2]);
    end
`endif
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_byte_loads();
    test_half_store();
    test_misaligned_word();
    test_illegal();
    test_back_to_back();
    test_random();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
